// File: rtl/code_entry_lock_if.sv
// Digit-entry bus between the keypad/digit source (master) and code_entry_lock (slave).
interface code_entry_lock_if #(
   parameter int unsigned DIGITS = 4
);
   logic [3:0]          digit;
   logic                digit_valid;
   logic [4*DIGITS-1:0] key;
   logic                clear;
   logic                relock;
   logic                busy;
   logic                unlocked;
   logic                locked_out;
   logic                match_pulse;
   logic                fail_pulse;
   logic [3:0]          tries;

   modport master (
      output digit, digit_valid, key, clear, relock,
      input  busy, unlocked, locked_out, match_pulse, fail_pulse, tries
   );

   modport slave (
      input  digit, digit_valid, key, clear, relock,
      output busy, unlocked, locked_out, match_pulse, fail_pulse, tries
   );
endinterface

// File: rtl/code_entry_lock.sv
// Digit-serial code lock: sticky per-digit compare, pass/fail decision, unlock and lockout timers.
// Optional CODE_LOCK_ERRCNT_EN adds a saturating err_count of all rejected codes since reset.
module code_entry_lock #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned UNLOCK_CYCLES  = 8,
   parameter int unsigned LOCKOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   code_entry_lock_if.slave  bus
`ifdef CODE_LOCK_ERRCNT_EN
   ,
   output logic [7:0]        err_count
`endif
);

   localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
   localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES);
   localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES);
   localparam logic [3:0]    TRY_MAX  = 4'(MAX_TRIES);

   typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCK, LOCKOUT} state_t;

   state_t          state, state_n;
   logic [IW-1:0]   idx, idx_n;
   logic            mism, mism_n;
   logic [TW-1:0]   timer, timer_n;
   logic [3:0]      tries_n;
   logic            match_n, fail_n;
   logic [3:0]      key_nib [DIGITS];
   logic [3:0]      tries_inc;
`ifdef CODE_LOCK_ERRCNT_EN
   logic [7:0]      err_count_n;
`endif

   for (genvar g = 0; g < DIGITS; g++) begin : g_nib
      assign key_nib[g] = bus.key[4*g +: 4];
   end

   assign tries_inc = (bus.tries == TRY_MAX) ? bus.tries : bus.tries + 4'd1;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      mism_n  = mism;
      timer_n = timer;
      tries_n = bus.tries;
      match_n = 1'b0;
      fail_n  = 1'b0;
`ifdef CODE_LOCK_ERRCNT_EN
      err_count_n = err_count;
`endif
      case (state)
         IDLE: begin
            if (bus.digit_valid) begin
               mism_n  = (bus.digit != key_nib[0]);
               idx_n   = IW'(1);
               state_n = (DIGITS == 1) ? CHECK : ENTRY;
            end
         end
         ENTRY: begin
            // clear wins over a digit arriving in the same cycle
            if (bus.clear) begin
               state_n = IDLE;
               idx_n   = '0;
               mism_n  = 1'b0;
            end else if (bus.digit_valid) begin
               mism_n = mism | (bus.digit != key_nib[idx]);
               if (idx == LAST_IDX) begin
                  state_n = CHECK;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         CHECK: begin
            mism_n = 1'b0;
            if (mism) begin
               fail_n  = 1'b1;
               tries_n = tries_inc;
`ifdef CODE_LOCK_ERRCNT_EN
               if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
`endif
               if (tries_inc == TRY_MAX) begin
                  state_n = LOCKOUT;
                  timer_n = T_LOCK;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               match_n = 1'b1;
               tries_n = '0;
               state_n = UNLOCK;
               timer_n = T_UNLOCK;
            end
         end
         UNLOCK: begin
            if (bus.relock || timer == TW'(1)) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer - 1'b1;
            end
         end
         LOCKOUT: begin
            if (timer == TW'(1)) begin
               state_n = IDLE;
               timer_n = '0;
               tries_n = '0;
            end else begin
               timer_n = timer - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         idx             <= '0;
         mism            <= 1'b0;
         timer           <= '0;
         bus.tries       <= '0;
         bus.match_pulse <= 1'b0;
         bus.fail_pulse  <= 1'b0;
`ifdef CODE_LOCK_ERRCNT_EN
         err_count       <= '0;
`endif
      end else begin
         state           <= state_n;
         idx             <= idx_n;
         mism            <= mism_n;
         timer           <= timer_n;
         bus.tries       <= tries_n;
         bus.match_pulse <= match_n;
         bus.fail_pulse  <= fail_n;
`ifdef CODE_LOCK_ERRCNT_EN
         err_count       <= err_count_n;
`endif
      end
   end

   assign bus.busy       = (state == ENTRY);
   assign bus.unlocked   = (state == UNLOCK);
   assign bus.locked_out = (state == LOCKOUT);

endmodule
